// File: rtl/apb_master_pkg.sv
// Shared types for the APB master bridge: FSM states, response record, default wait limit.
package apb_master_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } rsp_t;

    localparam int unsigned DefaultTimeoutCycles = 256;

endpackage

// File: rtl/apb_master_wdog.sv
// ACCESS-phase wait counter; raises expired on the Limit-th consecutive enabled cycle.
module apb_master_wdog #(
    parameter int unsigned Limit = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(Limit + 1);

    logic [CntW-1:0] cnt_q;

    assign expired = en && (cnt_q == CntW'(Limit - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Command/response to APB requester bridge with sticky interrupt flag.
// Optional ACCESS timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    input  logic                      interrupt_i,
    input  logic                      irq_clr_i,
    output logic                      irq_pending_o
);

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic [31:0]               wdata_q, wdata_d;
    rsp_t                      rsp_q, rsp_d;
    logic                      irq_q, irq_d;
    logic                      int_prev_q;
    logic                      timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_wdog #(
        .Limit (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (HCLK),
        .rst     (HRESET),
        .en      (state_q == StAccess),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    write_d = cmd_write_i;
                    wdata_d = cmd_wdata_i;
                    // Unaligned commands are rejected without touching the bus.
                    if (cmd_addr_i[1:0] != 2'b00) begin
                        rsp_d   = '{rdata: 32'h0, err: 1'b1, timeout: 1'b0};
                        state_d = StResp;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (PREADY) begin
                    rsp_d   = '{rdata: write_q ? 32'h0 : PRDATA, err: PSLVERR, timeout: 1'b0};
                    state_d = StResp;
                end else if (timeout_hit) begin
                    rsp_d   = '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh rising edge of the interrupt beats a simultaneous clear.
    always_comb begin
        irq_d = irq_q;
        if (interrupt_i && !int_prev_q) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0;
            rsp_q      <= '0;
            irq_q      <= 1'b0;
            int_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            rsp_q      <= rsp_d;
            irq_q      <= irq_d;
            int_prev_q <= interrupt_i;
        end
    end

    assign cmd_ready_o   = (state_q == StIdle);
    assign PSEL          = (state_q == StSetup) || (state_q == StAccess);
    assign PENABLE       = (state_q == StAccess);
    assign PWRITE        = write_q;
    assign PADDR         = addr_q;
    assign PWDATA        = wdata_q;
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;
    assign irq_pending_o = irq_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases plus randomized transactions.
module tb_apb_master_bridge;

    localparam int Tmo = 8;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
    logic [11:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;
    logic        interrupt_i = 1'b0, irq_clr_i = 1'b0, irq_pending_o;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 HCLK = ~HCLK;

    apb_master_bridge #(
        .APB_ADDR_WIDTH (12),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .interrupt_i   (interrupt_i),
        .irq_clr_i     (irq_clr_i),
        .irq_pending_o (irq_pending_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    // One complete command, modelled from the protocol rules: accept, optional SETUP/ACCESS,
    // then RESP held for rsp_hold cycles before rsp_ready_i is given.
    task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rdata, input logic slverr,
                           input int rsp_hold);
        bit          mis;
        bit          tmo;
        bit          err;
        bit          done;
        int          acc;
        logic [31:0] exp_rdata;
        mis = (addr[1:0] != 2'b00);
        tmo = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        @(negedge HCLK);
        check("cmd_ready_idle", cmd_ready_o, 1);
        next_cycle();
        cmd_valid_i = 1'b0;
        cmd_write_i = $urandom;
        cmd_addr_i  = 12'($urandom);
        cmd_wdata_i = $urandom;
        if (!mis) begin
            @(negedge HCLK);
            check("setup_psel", PSEL, 1);
            check("setup_penable", PENABLE, 0);
            check("setup_paddr", PADDR, addr);
            check("setup_pwrite", PWRITE, wr);
            check("setup_pwdata", PWDATA, wdata);
            check("setup_cmd_ready", cmd_ready_o, 0);
            next_cycle();
            acc  = 0;
            done = 1'b0;
            while (!done) begin
                PREADY  = (acc == delay);
                PRDATA  = PREADY ? rdata : $urandom;
                PSLVERR = PREADY ? slverr : 1'($urandom);
                @(negedge HCLK);
                check("access_psel", PSEL, 1);
                check("access_penable", PENABLE, 1);
                check("access_paddr", PADDR, addr);
                check("access_pwdata", PWDATA, wdata);
                check("access_rsp_valid", rsp_valid_o, 0);
                acc++;
                if (PREADY) begin
                    done = 1'b1;
                end else if (TmoEn && acc == Tmo) begin
                    done = 1'b1;
                    tmo  = 1'b1;
                end else if (acc > 1000) begin
                    check("access_bound", 32'(acc), 32'(delay + 1));
                    done = 1'b1;
                end
                next_cycle();
            end
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end
        err       = mis || tmo || slverr;
        exp_rdata = (mis || tmo || wr) ? 32'h0 : rdata;
        for (int h = 0; h <= rsp_hold; h++) begin
            rsp_ready_i = (h == rsp_hold);
            @(negedge HCLK);
            check("rsp_valid", rsp_valid_o, 1);
            check("rsp_rdata", rsp_rdata_o, exp_rdata);
            check("rsp_err", rsp_err_o, err);
            check("rsp_timeout", rsp_timeout_o, tmo);
            check("rsp_psel", PSEL, 0);
            check("rsp_cmd_ready", cmd_ready_o, 0);
            next_cycle();
        end
        rsp_ready_i = 1'b0;
        @(negedge HCLK);
        check("post_rsp_valid", rsp_valid_o, 0);
        check("post_cmd_ready", cmd_ready_o, 1);
        check("post_psel", PSEL, 0);
        next_cycle();
    endtask

    initial begin
        logic        pend;
        logic        prev_int;
        logic        wr;
        logic [11:0] addr;
        int          delay;

        #1;
        @(negedge HCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_rdata", rsp_rdata_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);
        check("rst_rsp_timeout", rsp_timeout_o, 0);
        check("rst_irq", irq_pending_o, 0);
        next_cycle();
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rel_cmd_ready", cmd_ready_o, 1);
        next_cycle();

        // Minimum-latency write, stalled read, slave error, unaligned reject.
        run_txn(1'b1, 12'h010, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0, 0);
        run_txn(1'b0, 12'h014, 32'h0, 4, 32'h0000_00C3, 1'b0, 1);
        run_txn(1'b0, 12'h018, 32'h0, 1, 32'h1234_5678, 1'b1, 0);
        run_txn(1'b1, 12'h013, 32'hFFFF_0000, 0, 32'h0, 1'b0, 2);
        if (TmoEn) begin
            run_txn(1'b0, 12'h01C, 32'h0, 20, 32'h5555_AAAA, 1'b0, 0);
        end

        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom);
            addr  = 12'($urandom);
            if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            delay = (TmoEn && $urandom_range(0, 5) == 0) ? 12 : int'($urandom_range(0, 5));
            run_txn(wr, addr, $urandom, delay, $urandom, 1'($urandom),
                    int'($urandom_range(0, 2)));
        end

        // Reset in the middle of ACCESS aborts the transfer without a response.
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 12'h020;
        next_cycle();
        cmd_valid_i = 1'b0;
        next_cycle();
        @(negedge HCLK);
        check("abort_in_access", PENABLE, 1);
        #2;
        HRESET = 1'b1;
        #1;
        check("abort_psel", PSEL, 0);
        check("abort_penable", PENABLE, 0);
        check("abort_rsp_valid", rsp_valid_o, 0);
        next_cycle();
        HRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check("abort_no_rsp", rsp_valid_o, 0);
            check("abort_idle", cmd_ready_o, 1);
            next_cycle();
        end

        // Rising interrupt with a simultaneous clear must leave the flag set.
        interrupt_i = 1'b1;
        irq_clr_i   = 1'b1;
        next_cycle();
        check("irq_set_wins", irq_pending_o, 1);
        next_cycle();
        check("irq_clr_level", irq_pending_o, 0);
        irq_clr_i = 1'b0;
        interrupt_i = 1'b0;
        pend     = 1'b0;
        prev_int = 1'b1;
        next_cycle();
        prev_int = 1'b0;
        for (int i = 0; i < 30; i++) begin
            interrupt_i = 1'($urandom);
            irq_clr_i   = ($urandom_range(0, 3) == 0);
            if (interrupt_i && !prev_int) pend = 1'b1;
            else if (irq_clr_i) pend = 1'b0;
            prev_int = interrupt_i;
            next_cycle();
            check("irq_random", irq_pending_o, pend);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
